// File: rtl/key_cond_pkg.sv
// Shared types and sizing helpers for the key conditioner.
package key_cond_pkg;

  typedef enum logic [2:0] {
    REL  = 3'd0,
    DB_P = 3'd1,
    PRS  = 3'd2,
    RPT  = 3'd3,
    DB_R = 3'd4
  } key_state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // A single shared counter covers every phase; keep at least one bit.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = max3(a, b, c);
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/key_channel.sv
// One key channel: synchroniser, debounce/repeat FSM and a single counter.
module key_channel
  import key_cond_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int DB_CYCLES     = 16,
  parameter int HOLD_CYCLES   = 64,
  parameter int REPEAT_CYCLES = 16,
  parameter int ACTIVE_LOW    = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic in,
  input  logic repeat_en,
  output logic level,
  output logic press,
  output logic release_pulse,
  output logic rpt
);

  localparam int CW = cnt_width(DB_CYCLES, HOLD_CYCLES, REPEAT_CYCLES);
  localparam logic IDLE = (ACTIVE_LOW != 0);
  localparam logic [CW-1:0] DB_LAST   = CW'(DB_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_CYCLES - 1);
  localparam logic [CW-1:0] ZERO      = {CW{1'b0}};
  localparam logic [CW-1:0] ONE       = CW'(1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  key_state_t             state, state_next;
  logic [CW-1:0]          cnt, cnt_next;
  logic                   level_next, press_next, release_next, rpt_next;

  // Synchroniser resets to the idle raw level so no press is seen out of reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync <= {SYNC_STAGES{IDLE}};
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], in};
    end
  end

  assign s = sync[SYNC_STAGES-1] ^ IDLE;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= REL;
      cnt           <= ZERO;
      level         <= 1'b0;
      press         <= 1'b0;
      release_pulse <= 1'b0;
      rpt           <= 1'b0;
    end else begin
      state         <= state_next;
      cnt           <= cnt_next;
      level         <= level_next;
      press         <= press_next;
      release_pulse <= release_next;
      rpt           <= rpt_next;
    end
  end

  // Release (s=0) is tested first in the held states so it beats repeat_en.
  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    press_next   = 1'b0;
    release_next = 1'b0;
    rpt_next     = 1'b0;
    case (state)
      REL: begin
        cnt_next = ZERO;
        if (s) begin
          state_next = DB_P;
        end else begin
          state_next = REL;
        end
      end
      DB_P: begin
        if (!s) begin
          state_next = REL;
          cnt_next   = ZERO;
        end else if (cnt == DB_LAST) begin
          state_next = PRS;
          cnt_next   = ZERO;
          press_next = 1'b1;
        end else begin
          cnt_next = cnt + ONE;
        end
      end
      PRS: begin
        if (!s) begin
          state_next = DB_R;
          cnt_next   = ZERO;
        end else if (repeat_en) begin
          if (cnt == HOLD_LAST) begin
            state_next = RPT;
            cnt_next   = ZERO;
            rpt_next   = 1'b1;
          end else begin
            cnt_next = cnt + ONE;
          end
        end else begin
          cnt_next = ZERO;
        end
      end
      RPT: begin
        if (!s) begin
          state_next = DB_R;
          cnt_next   = ZERO;
        end else if (!repeat_en) begin
          state_next = PRS;
          cnt_next   = ZERO;
        end else if (cnt == REP_LAST) begin
          cnt_next = ZERO;
          rpt_next = 1'b1;
        end else begin
          cnt_next = cnt + ONE;
        end
      end
      DB_R: begin
        if (s) begin
          state_next = PRS;
          cnt_next   = ZERO;
        end else if (cnt == DB_LAST) begin
          state_next   = REL;
          cnt_next     = ZERO;
          release_next = 1'b1;
        end else begin
          cnt_next = cnt + ONE;
        end
      end
      default: begin
        state_next = REL;
        cnt_next   = ZERO;
      end
    endcase
    level_next = (state_next == PRS) || (state_next == RPT) || (state_next == DB_R);
  end

endmodule

// File: rtl/key_conditioner.sv
// N independent key channels; release_pulse carries the release strobe
// because "release" is a reserved word in SystemVerilog.
module key_conditioner
  import key_cond_pkg::*;
#(
  parameter int N             = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int DB_CYCLES     = 16,
  parameter int HOLD_CYCLES   = 64,
  parameter int REPEAT_CYCLES = 16,
  parameter int ACTIVE_LOW    = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] in,
  input  logic [N-1:0] repeat_en,
  output logic [N-1:0] level,
  output logic [N-1:0] press,
  output logic [N-1:0] release_pulse,
  output logic [N-1:0] rpt
);

  for (genvar i = 0; i < N; i++) begin : g_ch
    key_channel #(
      .SYNC_STAGES  (SYNC_STAGES),
      .DB_CYCLES    (DB_CYCLES),
      .HOLD_CYCLES  (HOLD_CYCLES),
      .REPEAT_CYCLES(REPEAT_CYCLES),
      .ACTIVE_LOW   (ACTIVE_LOW)
    ) u_ch (
      .clk          (clk),
      .reset        (reset),
      .in           (in[i]),
      .repeat_en    (repeat_en[i]),
      .level        (level[i]),
      .press        (press[i]),
      .release_pulse(release_pulse[i]),
      .rpt          (rpt[i])
    );
  end

endmodule

// File: doc/key_conditioner.md
# key_conditioner

Parametrised multi-channel front end for raw push-button and switch inputs, sitting between board pins and the control FSMs. Per channel it synchronises the asynchronous input, debounces it, and emits single-cycle press and release pulses. It also provides optional auto-repeat pulses while a key is held. It generalises the one-shot rising-edge pulse generator to N channels with debounce, release detection, polarity and typematic repeat.

## Interface
- N, 4: number of independent channels.
- SYNC_STAGES, 2: synchroniser flop depth; must be ≥2.
- DB_CYCLES, 16: number of consecutive stable synchronised samples that accepts a level change; must be ≥1.
- HOLD_CYCLES, 64: cycles in PRESSED before the first repeat pulse; must be ≥1.
- REPEAT_CYCLES, 16: repeat pulse period after the first repeat; must be ≥1.
- ACTIVE_LOW, 0: when 1, a raw low level means pressed.
- clk  in  1  single clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high; one cycle fully initialises the block.
- in  in  N  raw asynchronous key inputs.
- repeat_en  in  N  per-channel auto-repeat enable; synchronous to clk.
- level  out  N  debounced pressed state.
- press  out  N  one-cycle pulse on an accepted press.
- release  out  N  one-cycle pulse on an accepted release.
- rpt  out  N  one-cycle auto-repeat pulse.

## Operation
- All outputs are registered. During reset and in the first cycle after it, every output is 0.
- Synchroniser flops reset to the inactive raw level: 0, or 1 when ACTIVE_LOW=1.
- s = synchroniser output XOR ACTIVE_LOW, so s=1 always means pressed.
- Each channel has an independent FSM and one counter cnt. Channels share nothing.
- FSM states and transitions:
  - REL: level=0. If s=1, go to DB_P with cnt=0.
  - DB_P: if s=0, return to REL (glitch rejected, no pulses). Otherwise cnt++. When cnt==DB_CYCLES-1 with s=1, go to PRS with cnt=0 and assert press.
  - PRS: level=1. If s=0, go to DB_R with cnt=0. Else if repeat_en=1, cnt++; when cnt==HOLD_CYCLES-1, go to RPT with cnt=0 and assert rpt. If repeat_en=0, cnt holds at 0.
  - RPT: level=1. If s=0, go to DB_R. If repeat_en=0, go to PRS with cnt=0. Otherwise cnt++; when cnt==REPEAT_CYCLES-1, assert rpt and reset cnt to 0.
  - DB_R: level stays 1. If s=1, return to PRS with cnt=0; no press pulse, and the repeat delay restarts. Otherwise cnt++; when cnt==DB_CYCLES-1, go to REL and assert release.
- Priority: s=0 (release path) overrides repeat_en changes in the same cycle.
- press and release are never asserted together on one channel.
- rpt is never asserted in the same cycle as press.
- Counter width is $clog2(max(DB_CYCLES, HOLD_CYCLES, REPEAT_CYCLES)). Counters never wrap, because every terminal compare resets them.
- Reset in any state returns to REL with all outputs 0. No release pulse is produced for a key held through reset.

## Timing
- Edge 0 is the first rising edge that samples the new raw level.
- s reflects it after edge SYNC_STAGES-1. DB_P is entered at edge SYNC_STAGES.
- press and level rise in the cycle after edge SYNC_STAGES+DB_CYCLES. Release latency is symmetric.
- With PRS entered at edge E and repeat_en=1 held: rpt is high after edges E+HOLD_CYCLES+k·REPEAT_CYCLES, for k≥0.
- Each pulse is exactly one cycle wide.
- Channels switching simultaneously produce pulses in the same cycle.

## Structure
- Package key_cond_pkg: key_state_t enum {REL, DB_P, PRS, RPT, DB_R}.
- Sub-module key_channel: synchroniser, FSM and counter for one channel, with the same parameters minus N.
- key_conditioner instantiates N copies of key_channel in a generate loop and concatenates their outputs.

## Test plan
Bench parameters: N=2, SYNC_STAGES=2, DB_CYCLES=4, HOLD_CYCLES=8, REPEAT_CYCLES=3.
- Reset: in=0 with reset held 3 cycles → level, press, release and rpt all 0 throughout and after reset.
- Clean press, repeat_en=0: in[0]=1 for 20 cycles, then 0 → press[0] high only after edge 6; level[0] goes 1; no rpt; release[0] high only after edge 6 counted from the falling sample; level[0] goes 0.
- Glitch and bounce: in[0] high for 3 cycles → no pulses, level stays 0. While pressed, drop in[0] for 2 cycles → no release and no second press.
- Auto-repeat: repeat_en[1]=1, in[1] held 30 cycles → press after edge 6, rpt after edges 14, 17, 20, 23, …; no rpt after the release is accepted.
- Concurrency and reset: both channels pressed in the same cycle → identical press timing on both. Assert reset while PRS → next cycle level=0 and no release pulse. Repeat the clean-press test with ACTIVE_LOW=1 and inverted stimulus → identical responses.
